// File: rtl/hazard_unit.sv
// Hazard/stall unit for the 5-stage MIPS pipeline: forwarding selects, load-use and
// branch-compare stalls, control-transfer flush, data-memory wait FSM with timeout.
module hazard_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REG_AW-1:0] Rs_D,
    input  logic [REG_AW-1:0] Rt_D,
    input  logic [REG_AW-1:0] Rs_E,
    input  logic [REG_AW-1:0] Rt_E,
    input  logic [REG_AW-1:0] WriteReg_E,
    input  logic [REG_AW-1:0] WriteReg_M,
    input  logic [REG_AW-1:0] WriteReg_W,
    input  logic              RegWrite_E,
    input  logic              RegWrite_M,
    input  logic              RegWrite_W,
    input  logic              MemtoReg_E,
    input  logic              MemtoReg_M,
    input  logic              MemRead_M,
    input  logic              MemWrite_M,
    input  logic              branch_D,
    input  logic              Jump_D,
    input  logic              PCSrc_D,
    input  logic              dmem_ready,
    output logic              ForwardA_D,
    output logic              ForwardB_D,
    output logic [1:0]        ForwardA_E,
    output logic [1:0]        ForwardB_E,
    output logic              Stall_F,
    output logic              Stall_D,
    output logic              Stall_E,
    output logic              Stall_M,
    output logic              Stall_W,
    output logic              Flush_D,
    output logic              Flush_E,
    output logic              Flush_M,
    output logic              Flush_W,
    output logic              dmem_req,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic memop, memstall, lwstall, brstall;

    // Register 0 is hardwired to zero, so a write to it is never a dependency.
    function automatic logic hit(input logic [REG_AW-1:0] wr, input logic [REG_AW-1:0] src);
        return (wr != '0) && (wr == src);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (&val) ? val : val + CNT_W'(1);
    endfunction

    always_comb begin
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        if (RegWrite_M && hit(WriteReg_M, Rs_E))      ForwardA_E = 2'b10;
        else if (RegWrite_W && hit(WriteReg_W, Rs_E)) ForwardA_E = 2'b01;
        if (RegWrite_M && hit(WriteReg_M, Rt_E))      ForwardB_E = 2'b10;
        else if (RegWrite_W && hit(WriteReg_W, Rt_E)) ForwardB_E = 2'b01;
        ForwardA_D = RegWrite_M && hit(WriteReg_M, Rs_D);
        ForwardB_D = RegWrite_M && hit(WriteReg_M, Rt_D);
    end

    always_comb begin
        memop    = MemRead_M | MemWrite_M;
        memstall = memop && !dmem_ready && (state_q != ABORT);
        dmem_req = memop && (state_q != ABORT);
        lwstall  = MemtoReg_E && (hit(WriteReg_E, Rs_D) || hit(WriteReg_E, Rt_D));
        brstall  = branch_D &&
                   ((RegWrite_E && (hit(WriteReg_E, Rs_D) || hit(WriteReg_E, Rt_D))) ||
                    (MemtoReg_M && (hit(WriteReg_M, Rs_D) || hit(WriteReg_M, Rt_D))));

        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Stall_E = 1'b0;
        Stall_M = 1'b0;
        Stall_W = 1'b0;
        Flush_D = 1'b0;
        Flush_E = 1'b0;
        Flush_M = 1'b0;
        Flush_W = 1'b0;

        // A memory wait freezes F..M and feeds bubbles into W; it outranks D-stage hazards.
        if (memstall) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Flush_W = 1'b1;
        end else if (lwstall || brstall) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end else begin
            Flush_D = PCSrc_D | Jump_D;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = Stall_D ? sat_inc(stall_cnt_q) : stall_cnt_q;

        case (state_q)
            IDLE: begin
                if (memstall) begin
                    state_d = WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            WAIT: begin
                if (!memop || dmem_ready) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(TIMEOUT)) begin
                    state_d = ABORT;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ABORT: begin
                // Access abandoned: release the pipeline for one cycle and flag the error.
                state_d   = IDLE;
                wcnt_d    = '0;
                mem_err_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: table of combinational vectors plus multi-cycle
// sequences for branch stall, memory wait, timeout, counter saturation and reset.
module tb_hazard_unit;

    localparam int RAW = 5;
    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic [RAW-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic rw_e, rw_m, rw_w, m2r_e, m2r_m, mr_m, mw_m, br, jmp, pcsrc, rdy;
        logic [1:0] fa_e, fb_e;
        logic fa_d, fb_d, st_fd, st_em, fl_d, fl_e, fl_w, req;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    logic [RAW-1:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
    logic MemRead_M, MemWrite_M, branch_D, Jump_D, PCSrc_D, dmem_ready;
    logic ForwardA_D, ForwardB_D;
    logic [1:0] ForwardA_E, ForwardB_E;
    logic Stall_F, Stall_D, Stall_E, Stall_M, Stall_W;
    logic Flush_D, Flush_E, Flush_M, Flush_W;
    logic dmem_req, mem_err;
    logic [CW-1:0] stall_cycles;
    logic [15:0] outs;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 CLK = ~CLK;

    hazard_unit #(.REG_AW(RAW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
        .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M),
        .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
        .branch_D(branch_D), .Jump_D(Jump_D), .PCSrc_D(PCSrc_D),
        .dmem_ready(dmem_ready),
        .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Stall_W(Stall_W),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M), .Flush_W(Flush_W),
        .dmem_req(dmem_req), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    assign outs = {ForwardA_E, ForwardB_E, ForwardA_D, ForwardB_D, Stall_F, Stall_D,
                   Stall_E, Stall_M, Stall_W, Flush_D, Flush_E, Flush_M, Flush_W, dmem_req};

    function automatic logic [15:0] exp_outs(input vec_t v);
        return {v.fa_e, v.fb_e, v.fa_d, v.fb_d, v.st_fd, v.st_fd, v.st_em, v.st_em,
                1'b0, v.fl_d, v.fl_e, 1'b0, v.fl_w, v.req};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        Rs_D = v.rs_d; Rt_D = v.rt_d; Rs_E = v.rs_e; Rt_E = v.rt_e;
        WriteReg_E = v.wr_e; WriteReg_M = v.wr_m; WriteReg_W = v.wr_w;
        RegWrite_E = v.rw_e; RegWrite_M = v.rw_m; RegWrite_W = v.rw_w;
        MemtoReg_E = v.m2r_e; MemtoReg_M = v.m2r_m;
        MemRead_M = v.mr_m; MemWrite_M = v.mw_m;
        branch_D = v.br; Jump_D = v.jmp; PCSrc_D = v.pcsrc; dmem_ready = v.rdy;
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase of the next cycle.
    task automatic run_vec(input string name, input vec_t v);
        apply(v);
        #1;
        check({name, " outs"}, 32'(outs), 32'(exp_outs(v)));
        check({name, " stall_cycles"}, 32'(stall_cycles), exp_cnt);
        if (RST) exp_cnt = 0;
        else if (v.st_fd && exp_cnt < CNT_MAX) exp_cnt++;
        @(posedge CLK);
        #1;
    endtask

    vec_t tbl[$];
    vec_t v, memw, lw;

    initial begin
        // Combinational table: no memory wait is provoked here.
        v = '0; tbl.push_back(v);
        v = '0; v.rw_m = 1; v.wr_m = 8; v.rw_w = 1; v.wr_w = 8; v.rs_e = 8; v.fa_e = 2'b10; tbl.push_back(v);
        v = '0; v.rw_m = 1; v.wr_m = 0; v.rw_w = 1; v.wr_w = 8; v.rs_e = 8; v.fa_e = 2'b01; tbl.push_back(v);
        v = '0; v.rw_w = 1; v.wr_w = 12; v.rt_e = 12; v.fb_e = 2'b01; tbl.push_back(v);
        v = '0; v.rw_m = 1; v.rw_w = 1; tbl.push_back(v);
        v = '0; v.wr_m = 5; v.rs_e = 5; v.rt_e = 5; tbl.push_back(v);
        v = '0; v.rw_m = 1; v.wr_m = 7; v.rs_d = 7; v.rt_d = 7; v.rt_e = 7; v.fa_d = 1; v.fb_d = 1; v.fb_e = 2'b10; tbl.push_back(v);
        v = '0; v.m2r_e = 1; v.wr_e = 9; v.rt_d = 9; v.st_fd = 1; v.fl_e = 1; tbl.push_back(v);
        v = '0; v.m2r_e = 1; v.wr_e = 9; v.rs_d = 9; v.jmp = 1; v.st_fd = 1; v.fl_e = 1; tbl.push_back(v);
        v = '0; v.m2r_e = 1; v.wr_e = 0; v.rs_d = 0; tbl.push_back(v);
        v = '0; v.br = 1; v.rw_e = 1; v.wr_e = 4; v.rs_d = 4; v.st_fd = 1; v.fl_e = 1; tbl.push_back(v);
        v = '0; v.br = 1; v.m2r_m = 1; v.wr_m = 4; v.rt_d = 4; v.st_fd = 1; v.fl_e = 1; tbl.push_back(v);
        v = '0; v.br = 1; v.rw_e = 1; v.wr_e = 4; v.rs_d = 5; v.pcsrc = 1; v.fl_d = 1; tbl.push_back(v);
        v = '0; v.jmp = 1; v.fl_d = 1; tbl.push_back(v);
        v = '0; v.rw_e = 1; v.wr_e = 4; v.rs_d = 4; tbl.push_back(v);
        v = '0; v.mr_m = 1; v.rdy = 1; v.req = 1; tbl.push_back(v);
        v = '0; v.mw_m = 1; v.rdy = 1; v.pcsrc = 1; v.req = 1; v.fl_d = 1; tbl.push_back(v);

        memw = '0; memw.mr_m = 1; memw.rdy = 0;
        memw.st_fd = 1; memw.st_em = 1; memw.fl_w = 1; memw.req = 1;
        lw = '0; lw.m2r_e = 1; lw.wr_e = 9; lw.rt_d = 9; lw.st_fd = 1; lw.fl_e = 1;

        RST = 1'b1;
        apply('0);
        repeat (2) @(posedge CLK);
        #1;
        check("reset stall_cycles", 32'(stall_cycles), 0);
        check("reset mem_err", 32'(mem_err), 0);
        RST = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Branch operand produced in E, then loaded in M, then resolved taken.
        v = '0; v.br = 1; v.rw_e = 1; v.wr_e = 4; v.rs_d = 4; v.st_fd = 1; v.fl_e = 1;
        run_vec("br_e", v);
        v = '0; v.br = 1; v.rw_m = 1; v.m2r_m = 1; v.wr_m = 4; v.rs_d = 4; v.st_fd = 1; v.fl_e = 1; v.fa_d = 1;
        run_vec("br_m_load", v);
        v = '0; v.br = 1; v.rs_d = 4; v.rw_w = 1; v.wr_w = 4; v.pcsrc = 1; v.fl_d = 1;
        run_vec("br_taken", v);

        // Three wait cycles, a load-use hazard underneath the second, then ready.
        run_vec("memw0", memw);
        v = memw; v.m2r_e = 1; v.wr_e = 9; v.rt_d = 9;
        run_vec("memw1_lw", v);
        run_vec("memw2", memw);
        v = '0; v.mr_m = 1; v.rdy = 1; v.req = 1;
        run_vec("memw_ready", v);
        v = '0; v.rdy = 1;
        run_vec("memw_idle", v);

        // Timeout: TIMEOUT+1 stall cycles, one abort cycle, then sticky error.
        for (int i = 0; i <= TO; i++) run_vec($sformatf("to_stall%0d", i), memw);
        check("to mem_err before abort", 32'(mem_err), 0);
        v = '0; v.mr_m = 1; v.rdy = 0;
        run_vec("to_abort", v);
        v = '0; v.rdy = 1;
        run_vec("to_after", v);
        check("to mem_err sticky", 32'(mem_err), 1);
        run_vec("to_after2", '0);
        check("to mem_err held", 32'(mem_err), 1);

        // Drive the counter into saturation.
        for (int i = 0; i < 3; i++) run_vec($sformatf("sat%0d", i), lw);
        run_vec("sat_hold", '0);
        check("sat value", 32'(stall_cycles), CNT_MAX);

        // Reset in the middle of a wait; a full-length timeout afterwards shows wcnt restarted.
        run_vec("rw0", memw);
        run_vec("rw1", memw);
        RST = 1'b1;
        run_vec("rw_rst", memw);
        RST = 1'b0;
        check("rw mem_err cleared", 32'(mem_err), 0);
        check("rw stall_cycles cleared", 32'(stall_cycles), 0);
        for (int i = 0; i <= TO; i++) run_vec($sformatf("rw_stall%0d", i), memw);
        v = '0; v.mr_m = 1;
        run_vec("rw_abort", v);
        run_vec("rw_after", '0);
        check("rw mem_err", 32'(mem_err), 1);
        check("rw stall_cycles", 32'(stall_cycles), TO + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
